// File: rtl/count_checker_if.sv
// Counter-stream monitor bus: sampled counter/mode/clear in, lock and error status out.
interface count_checker_if #(
  parameter int WIDTH = 5,
  parameter int ERR_W = 8
);
  logic             valid;
  logic             mode;
  logic [WIDTH-1:0] counter;
  logic             clr;
  logic             locked;
  logic             err;
  logic             wrap;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output valid, mode, counter, clr,
    input  locked, err, wrap, err_cnt
  );

  modport slave (
    input  valid, mode, counter, clr,
    output locked, err, wrap, err_cnt
  );
endinterface

// File: rtl/count_checker.sv
// Up/down counter stream checker: locks onto the sequence, flags wraps, mismatches and illegal values.
// Response one cycle after each valid sample; no backpressure, the checker samples every valid cycle.
module count_checker #(
  parameter int WIDTH    = 5,
  parameter int MAX_VAL  = 30,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  count_checker_if.slave bus
);
  localparam logic [1:0]       UNLOCKED = 2'd0;
  localparam logic [1:0]       ACQUIRE  = 2'd1;
  localparam logic [1:0]       LOCKED   = 2'd2;
  localparam logic [WIDTH-1:0] MAXV     = WIDTH'(MAX_VAL);
  localparam logic [2:0]       LOCKV    = 3'(LOCK_CNT);

  logic [1:0]       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_exp, w_exp_nxt;
  logic [2:0]       r_run, w_run_nxt;
  logic             r_last_mode, w_mode_nxt;
  logic             r_err, w_err_nxt;
  logic             r_wrap, w_wrap_nxt;
  logic [ERR_W-1:0] r_err_cnt;
  logic             w_inc;
  logic [WIDTH-1:0] w_seed;
  logic             w_illegal;
  logic             w_in_step;
  logic             w_wrap_cond;
  logic [2:0]       w_run_inc;

  function automatic logic [WIDTH-1:0] f_next(input logic [WIDTH-1:0] v, input logic m);
    if (m)
      return (v == '0) ? MAXV : v - WIDTH'(1);
    else
      return (v == MAXV) ? '0 : v + WIDTH'(1);
  endfunction

  assign w_seed      = f_next(bus.counter, bus.mode);
  assign w_illegal   = bus.counter > MAXV;
  assign w_in_step   = (bus.mode == r_last_mode) && (bus.counter == r_exp);
  assign w_wrap_cond = bus.mode ? (bus.counter == MAXV) : (bus.counter == '0);
  assign w_run_inc   = r_run + 3'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = r_exp;
    w_run_nxt   = r_run;
    w_mode_nxt  = r_last_mode;
    w_err_nxt   = 1'b0;
    w_wrap_nxt  = 1'b0;
    w_inc       = 1'b0;
    if (bus.valid) begin
      if (w_illegal) begin
        w_err_nxt   = 1'b1;
        w_inc       = 1'b1;
        w_state_nxt = UNLOCKED;
      end else begin
        w_mode_nxt = bus.mode;
        // On an in-step sample next(counter) equals next(exp), so reseed and advance coincide.
        w_exp_nxt  = w_seed;
        case (r_state)
          ACQUIRE: begin
            if (w_in_step) begin
              w_run_nxt = w_run_inc;
              if (w_run_inc == LOCKV)
                w_state_nxt = LOCKED;
            end else begin
              w_run_nxt = 3'd0;
            end
          end
          LOCKED: begin
            if (w_in_step) begin
              w_wrap_nxt = w_wrap_cond;
            end else begin
              w_err_nxt   = (bus.mode == r_last_mode);
              w_inc       = (bus.mode == r_last_mode);
              w_run_nxt   = 3'd0;
              w_state_nxt = ACQUIRE;
            end
          end
          default: begin
            w_run_nxt   = 3'd0;
            w_state_nxt = ACQUIRE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= UNLOCKED;
      r_exp       <= '0;
      r_run       <= 3'd0;
      r_last_mode <= 1'b0;
      r_err       <= 1'b0;
      r_wrap      <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_exp       <= w_exp_nxt;
      r_run       <= w_run_nxt;
      r_last_mode <= w_mode_nxt;
      r_err       <= w_err_nxt;
      r_wrap      <= w_wrap_nxt;
      if (bus.clr)
        r_err_cnt <= '0;
      else if (w_inc && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

  assign bus.locked  = (r_state == LOCKED);
  assign bus.err     = r_err;
  assign bus.wrap    = r_wrap;
  assign bus.err_cnt = r_err_cnt;
endmodule

// File: tb/tb_count_checker.sv
// Randomized and directed bench for count_checker against a transaction-level model.
module tb_count_checker;
  localparam int MAX  = 30;
  localparam int LOCK = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  count_checker_if #(.WIDTH(5), .ERR_W(8)) bus();

  count_checker #(.WIDTH(5), .MAX_VAL(MAX), .LOCK_CNT(LOCK), .ERR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ph;   // 0 searching, 1 acquiring, 2 locked
    int ex;
    int run;
    int cnt;
    bit lm;
    bit err;
    bit wrap;
  } mst_t;

  mst_t m = '{default: 0};
  int   n_vec  = 0;
  int   n_miss = 0;
  bit   cmp_en = 1'b0;

  function automatic int nxt(int v, bit md);
    return md ? (v + MAX) % (MAX + 1) : (v + 1) % (MAX + 1);
  endfunction

  function automatic mst_t step(mst_t s, bit v, bit md, int c, bit cl);
    mst_t o = s;
    bit inc = 1'b0;
    o.err  = 1'b0;
    o.wrap = 1'b0;
    if (v) begin
      if (c > MAX) begin
        o.err = 1'b1;
        inc   = 1'b1;
        o.ph  = 0;
      end else if (s.ph == 0) begin
        o.ex = nxt(c, md); o.run = 0; o.ph = 1; o.lm = md;
      end else if (md != s.lm || c != s.ex) begin
        if (s.ph == 2 && md == s.lm) begin
          o.err = 1'b1;
          inc   = 1'b1;
        end
        o.ex = nxt(c, md); o.run = 0; o.ph = 1; o.lm = md;
      end else begin
        o.ex = nxt(c, md);
        o.lm = md;
        if (s.ph == 1) begin
          o.run = s.run + 1;
          if (o.run == LOCK) o.ph = 2;
        end else begin
          o.wrap = md ? (c == MAX) : (c == 0);
        end
      end
    end
    if (cl)       o.cnt = 0;
    else if (inc) o.cnt = (s.cnt < 255) ? s.cnt + 1 : 255;
    return o;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{default: 0};
    else        m <= step(m, bus.valid, bus.mode, int'(bus.counter), bus.clr);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("locked",  32'(bus.locked),  32'(m.ph == 2));
      chk("err",     32'(bus.err),     32'(m.err));
      chk("wrap",    32'(bus.wrap),    32'(m.wrap));
      chk("err_cnt", 32'(bus.err_cnt), 32'(m.cnt));
    end
  end

  task automatic smp(input bit v, input bit md, input int c, input bit cl);
    bus.valid   = v;
    bus.mode    = md;
    bus.counter = 5'(c);
    bus.clr     = cl;
    @(negedge clk);
  endtask

  initial begin
    int tv;
    bit tm;
    bus.valid = 1'b0; bus.mode = 1'b0; bus.counter = 5'd0; bus.clr = 1'b0;
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_locked", 32'(bus.locked), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_cnt", 32'(bus.err_cnt), 0);

    smp(1, 0, 0, 0);  chk("t1_lock0", 32'(bus.locked), 0);
    smp(1, 0, 1, 0);  chk("t1_lock1", 32'(bus.locked), 0);
    smp(1, 0, 2, 0);  chk("t1_lock2", 32'(bus.locked), 1);
    chk("t1_model_ph", 32'(m.ph), 2);
    smp(1, 0, 3, 0);  chk("t1_err", 32'(bus.err), 0);
    chk("t1_cnt", 32'(bus.err_cnt), 0);

    for (int c = 4; c <= 30; c++) smp(1, 0, c, 0);
    chk("t2_nowrap30", 32'(bus.wrap), 0);
    smp(1, 0, 0, 0);  chk("t2_wrap", 32'(bus.wrap), 1);
    chk("t2_err", 32'(bus.err), 0);
    chk("t2_model_wrap", 32'(m.wrap), 1);
    smp(1, 0, 1, 0);  chk("t2_wrap_pulse", 32'(bus.wrap), 0);

    smp(1, 1, 6, 0);  chk("t3_dirchg_err", 32'(bus.err), 0);
    chk("t3_dirchg_lock", 32'(bus.locked), 0);
    smp(1, 1, 5, 0);
    smp(1, 1, 4, 0);  chk("t3_relock", 32'(bus.locked), 1);
    for (int c = 3; c >= 0; c--) smp(1, 1, c, 0);
    chk("t3_nowrap0", 32'(bus.wrap), 0);
    smp(1, 1, 30, 0); chk("t3_wrap", 32'(bus.wrap), 1);
    chk("t3_locked", 32'(bus.locked), 1);

    smp(1, 0, 3, 0); smp(1, 0, 4, 0); smp(1, 0, 5, 0); smp(1, 0, 6, 0);
    smp(1, 0, 9, 0);  chk("t4_err", 32'(bus.err), 1);
    chk("t4_cnt", 32'(bus.err_cnt), 1);
    chk("t4_unlock", 32'(bus.locked), 0);
    smp(1, 0, 10, 0); chk("t4_err_pulse", 32'(bus.err), 0);
    smp(1, 0, 11, 0); chk("t4_relock", 32'(bus.locked), 1);

    smp(1, 0, 12, 0);
    smp(1, 1, 11, 0); chk("t5_err", 32'(bus.err), 0);
    chk("t5_unlock", 32'(bus.locked), 0);
    smp(1, 1, 10, 0);
    smp(1, 1, 9, 0);  chk("t5_relock", 32'(bus.locked), 1);
    smp(1, 1, 31, 0); chk("t5_illegal_err", 32'(bus.err), 1);
    chk("t5_cnt", 32'(bus.err_cnt), 2);
    chk("t5_model_cnt", 32'(m.cnt), 2);
    chk("t5_unlock2", 32'(bus.locked), 0);

    repeat (260) smp(1, 0, 31, 0);
    chk("t6_sat", 32'(bus.err_cnt), 255);
    smp(1, 0, 31, 1); chk("t6_clr_err", 32'(bus.err), 1);
    chk("t6_clr_cnt", 32'(bus.err_cnt), 0);

    tv = 0; tm = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit cl;
      r  = $urandom_range(0, 99);
      cl = ($urandom_range(0, 31) == 0);
      if (r < 8) begin
        smp(0, 1'($urandom_range(0, 1)), $urandom_range(0, 31), cl);
      end else if (r < 11) begin
        smp(1, tm, 31, cl);
      end else begin
        if (r < 15)      tm = ~tm;
        else if (r < 19) tv = $urandom_range(0, MAX);
        else             tv = nxt(tv, tm);
        smp(1, tm, tv, cl);
      end
    end

    for (int c = 0; c < 4; c++) smp(1, 0, c, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_locked", 32'(bus.locked), 0);
    chk("arst_err", 32'(bus.err), 0);
    chk("arst_wrap", 32'(bus.wrap), 0);
    chk("arst_cnt", 32'(bus.err_cnt), 0);
    bus.valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    smp(1, 0, 7, 0); smp(1, 0, 8, 0); smp(1, 0, 9, 0);
    chk("post_rst_lock", 32'(bus.locked), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
